// File: rtl/aes_pkg.sv
// Shared constants and GF(2^8) helpers for the AES-128 inverse cipher.
// FSM encodings, Rcon, forward S-box (key schedule) and InvShiftRows mapping.
package aes_pkg;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] KEYEXP = 2'd1;
   localparam logic [1:0] ROUND  = 2'd2;

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[2047 - 8*int'(x) -: 8];
   endfunction

   // RotWord then SubWord, as used by both key-schedule directions.
   function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
      return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] i);
      case (i)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Byte i = 4*col + row; output row r, column c takes input column (c - r) mod 4.
   function automatic int isr_idx(input int i);
      return 4 * (((i / 4) - (i % 4) + 4) % 4) + (i % 4);
   endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box lookup.
module aes_inv_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);

   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   assign y = INV_SBOX[2047 - 8*int'(a) -: 8];

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 decryption: forward key expansion to rk10, then one
// inverse round per cycle while the key schedule is rolled back.
module aes_inv_cipher
   import aes_pkg::*;
#(
   parameter int ROUNDS = 10
) (
   input  logic         AES_clk,
   input  logic         AES_rst_n,
   input  logic         AES_en,
   input  logic [127:0] AES_data_in,
   input  logic [127:0] AES_key_in,
   output logic [127:0] AES_data_out,
   output logic         AES_data_out_valid,
   output logic         AES_busy
);

   if (ROUNDS != 10) begin : g_rounds_check
      $error("aes_inv_cipher: only ROUNDS = 10 is supported");
   end

   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
              gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
              gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
              gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
   endfunction

   logic [1:0]   state;
   logic         en_d;
   logic [3:0]   cnt;
   logic [3:0]   rnd;
   logic [127:0] data;
   logic [127:0] st;
   logic [127:0] key;

   logic [127:0] sr, sb, ark, imc;
   logic [31:0]  f0, f1, f2, f3, r0, r1, r2, r3;
   logic [127:0] key_fwd, key_rev;

   for (genvar i = 0; i < 16; i++) begin : g_byte
      localparam int Src = isr_idx(i);
      assign sr[127-8*i -: 8] = st[127-8*Src -: 8];
      aes_inv_sbox u_inv_sbox (
         .a (sr[127-8*i -: 8]),
         .y (sb[127-8*i -: 8])
      );
   end

   assign ark = sb ^ key;

   for (genvar c = 0; c < 4; c++) begin : g_col
      assign imc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
   end

   assign f0 = key[127:96] ^ sub_rot_word(key[31:0]) ^ {rcon(cnt), 24'h0};
   assign f1 = key[95:64] ^ f0;
   assign f2 = key[63:32] ^ f1;
   assign f3 = key[31:0]  ^ f2;
   assign key_fwd = {f0, f1, f2, f3};

   // Undo one expansion step: rk_r -> rk_(r-1) with Rcon[r], r taken from rnd.
   assign r3 = key[31:0]  ^ key[63:32];
   assign r2 = key[63:32] ^ key[95:64];
   assign r1 = key[95:64] ^ key[127:96];
   assign r0 = key[127:96] ^ sub_rot_word(r3) ^ {rcon(rnd), 24'h0};
   assign key_rev = {r0, r1, r2, r3};

   always_ff @(posedge AES_clk or negedge AES_rst_n) begin
      if (!AES_rst_n) begin
         state              <= IDLE;
         en_d               <= 1'b0;
         cnt                <= '0;
         rnd                <= '0;
         data               <= '0;
         st                 <= '0;
         key                <= '0;
         AES_data_out       <= '0;
         AES_data_out_valid <= 1'b0;
         AES_busy           <= 1'b0;
      end else begin
         en_d               <= AES_en;
         AES_data_out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (AES_en && !en_d) begin
                  data     <= AES_data_in;
                  key      <= AES_key_in;
                  AES_busy <= 1'b1;
                  cnt      <= 4'd1;
                  state    <= KEYEXP;
               end
            end
            KEYEXP: begin
               key <= key_fwd;
               cnt <= cnt + 4'd1;
               if (cnt == 4'd10) begin
                  rnd   <= 4'd10;
                  state <= ROUND;
               end
            end
            ROUND: begin
               // rnd 10 is the initial AddRoundKey, 0 the final round without InvMixColumns.
               if (rnd == 4'd10) st <= data ^ key;
               else if (rnd != 4'd0) st <= imc;
               if (rnd != 4'd0) begin
                  key <= key_rev;
                  rnd <= rnd - 4'd1;
               end else begin
                  AES_data_out       <= ark;
                  AES_data_out_valid <= 1'b1;
                  AES_busy           <= 1'b0;
                  state              <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Scoreboard bench for aes_inv_cipher using FIPS-197 and SP800-38A vectors.
module tb_aes_inv_cipher;

   logic         AES_clk = 1'b0;
   logic         AES_rst_n;
   logic         AES_en;
   logic [127:0] AES_data_in;
   logic [127:0] AES_key_in;
   logic [127:0] AES_data_out;
   logic         AES_data_out_valid;
   logic         AES_busy;

   aes_inv_cipher #(.ROUNDS(10)) dut (
      .AES_clk            (AES_clk),
      .AES_rst_n          (AES_rst_n),
      .AES_en             (AES_en),
      .AES_data_in        (AES_data_in),
      .AES_key_in         (AES_key_in),
      .AES_data_out       (AES_data_out),
      .AES_data_out_valid (AES_data_out_valid),
      .AES_busy           (AES_busy)
   );

   always #5 AES_clk = ~AES_clk;

   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C3 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
   localparam logic [127:0] P3 = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [127:0] C4 = 128'hf5d3d58503b9699de785895a96fdbaaf;
   localparam logic [127:0] P4 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

   typedef struct {
      logic [127:0] pt;
      int           due;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   bit   pend_pulse = 1'b0;
   int   cap;

   always @(posedge AES_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, required %h", name, act, exp);
   endtask

   // Monitor: every valid pulse must match the oldest outstanding expectation.
   always @(negedge AES_clk) begin
      exp_t e;
      if (pend_pulse) begin
         check("valid_one_cycle", 128'(AES_data_out_valid), 128'd0);
         pend_pulse = 1'b0;
      end
      if (AES_data_out_valid) begin
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_valid: got valid=1 at cycle %0d, required no pulse", cyc);
         end else begin
            e = sb.pop_front();
            check("plaintext", AES_data_out, e.pt);
            check("latency", 128'(cyc), 128'(e.due));
            pend_pulse = 1'b1;
         end
      end
   end

   // Called at a negedge; the following posedge is the capture edge.
   task automatic start_op(input logic [127:0] k, input logic [127:0] ct,
                           input logic [127:0] pt, input bit push, output int c0);
      exp_t e;
      AES_key_in  = k;
      AES_data_in = ct;
      AES_en      = 1'b1;
      c0          = cyc + 1;
      if (push) begin
         e.pt  = pt;
         e.due = c0 + 21;
         sb.push_back(e);
      end
   endtask

   task automatic drain();
      int k = 0;
      while (sb.size() != 0 && k < 200) begin
         @(negedge AES_clk);
         k++;
      end
      check("drain_timeout", 128'(sb.size()), 128'd0);
      repeat (2) @(negedge AES_clk);
   endtask

   task automatic run_simple(input logic [127:0] k, input logic [127:0] ct,
                             input logic [127:0] pt);
      start_op(k, ct, pt, 1'b1, cap);
      @(negedge AES_clk);
      AES_en = 1'b0;
      check("busy_after_capture", 128'(AES_busy), 128'd1);
      drain();
      check("busy_idle", 128'(AES_busy), 128'd0);
   endtask

   initial begin
      AES_rst_n   = 1'b0;
      AES_en      = 1'b0;
      AES_data_in = '0;
      AES_key_in  = '0;
      repeat (3) @(negedge AES_clk);
      check("reset_busy", 128'(AES_busy), 128'd0);
      check("reset_valid", 128'(AES_data_out_valid), 128'd0);
      check("reset_out", AES_data_out, 128'd0);
      AES_rst_n = 1'b1;
      @(negedge AES_clk);

      run_simple(K1, C1, P1);
      run_simple(K2, C2, P2);

      // Level held for 51 cycles with the ciphertext changed before T5.
      start_op(K1, C1, P1, 1'b1, cap);
      for (int i = 1; i <= 51; i++) begin
         @(negedge AES_clk);
         if (i == 5) AES_data_in = 128'ha6f2daeb140fa720529e75d521cbc681;
      end
      AES_en = 1'b0;
      drain();

      run_simple(K2, C3, P3);
      run_simple(K2, C4, P4);

      // Reset right after T10, then a clean restart.
      start_op(K1, C1, P1, 1'b0, cap);
      @(negedge AES_clk);
      AES_en = 1'b0;
      repeat (9) @(negedge AES_clk);
      @(posedge AES_clk);
      #1 AES_rst_n = 1'b0;
      #1;
      check("midop_reset_busy", 128'(AES_busy), 128'd0);
      check("midop_reset_valid", 128'(AES_data_out_valid), 128'd0);
      check("midop_reset_out", AES_data_out, 128'd0);
      @(negedge AES_clk);
      AES_rst_n = 1'b1;
      @(negedge AES_clk);
      run_simple(K2, C2, P2);

      // Back-to-back: en low before T20, second start on T22.
      start_op(K1, C1, P1, 1'b1, cap);
      repeat (20) @(negedge AES_clk);
      AES_en = 1'b0;
      repeat (2) @(negedge AES_clk);
      start_op(K2, C2, P2, 1'b1, cap);
      @(negedge AES_clk);
      AES_en = 1'b0;
      check("b2b_busy", 128'(AES_busy), 128'd1);
      repeat (20) @(negedge AES_clk);
      check("hold_first_result", AES_data_out, P1);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
